// File: rtl/axi3_slave_mem.sv
// AXI3 slave backed by a byte-strobed word memory.
// Read and write run independently, each with one outstanding burst.
module axi3_slave_mem #(
    parameter int unsigned DATA_BYTES    = 4,
    parameter int unsigned ADDR_BYTES    = 4,
    parameter int unsigned NUM_ID_BITS_P = 4,
    parameter int unsigned MEM_WORDS     = 256
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    // AW
    input  logic                       awvalid,
    input  logic [ADDR_BYTES*8-1:0]    awaddr,
    input  logic [2:0]                 awsize,
    input  logic [3:0]                 awcache,
    input  logic [2:0]                 awprot,
    input  logic [1:0]                 awlock,
    input  logic [1:0]                 awburst,
    input  logic [NUM_ID_BITS_P-1:0]   awid,
    input  logic [3:0]                 awlen,
    output logic                       awready,
    // W
    input  logic                       wvalid,
    input  logic                       wlast,
    input  logic [DATA_BYTES*8-1:0]    wdata,
    input  logic [DATA_BYTES-1:0]      wstrb,
    input  logic [NUM_ID_BITS_P-1:0]   wid,
    output logic                       wready,
    // B
    input  logic                       bready,
    output logic                       bvalid,
    output logic [1:0]                 bresp,
    output logic [NUM_ID_BITS_P-1:0]   bid,
    // AR
    input  logic                       arvalid,
    input  logic [ADDR_BYTES*8-1:0]    araddr,
    input  logic [2:0]                 arsize,
    input  logic [3:0]                 arcache,
    input  logic [2:0]                 arprot,
    input  logic [1:0]                 arlock,
    input  logic [1:0]                 arburst,
    input  logic [NUM_ID_BITS_P-1:0]   arid,
    input  logic [3:0]                 arlen,
    output logic                       arready,
    // R
    input  logic                       rready,
    output logic                       rvalid,
    output logic                       rlast,
    output logic [DATA_BYTES*8-1:0]    rdata,
    output logic [1:0]                 rresp,
    output logic [NUM_ID_BITS_P-1:0]   rid
);

    localparam int unsigned DW     = DATA_BYTES * 8;
    localparam int unsigned AW_W   = ADDR_BYTES * 8;
    localparam int unsigned OFFS   = $clog2(DATA_BYTES);
    localparam int unsigned WIDX   = $clog2(MEM_WORDS);
    localparam int unsigned MEM_AB = OFFS + WIDX;

    localparam logic [2:0] FULL_SIZE   = 3'(OFFS);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [1:0] burst_resp(input logic [AW_W-1:0] addr,
                                              input logic [2:0] size,
                                              input logic [1:0] burst,
                                              input logic [3:0] len);
        logic       wrap_len_ok;
        logic [1:0] resp;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        resp = RESP_OKAY;
        if (|addr[AW_W-1:MEM_AB]) begin
            resp = RESP_DECERR;
        end else if (size != FULL_SIZE || burst == BURST_RSVD ||
                     (burst == BURST_WRAP && !wrap_len_ok)) begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

    // WRAP keeps the upper bits of the aligned (len+1)-beat block and wraps the offset
    function automatic logic [AW_W-1:0] next_addr(input logic [AW_W-1:0] addr,
                                                  input logic [1:0] burst,
                                                  input logic [3:0] len);
        logic [AW_W-1:0] incr;
        logic [AW_W-1:0] mask;
        logic [AW_W-1:0] res;
        incr = addr + AW_W'(DATA_BYTES);
        mask = ((AW_W'(len) + AW_W'(1)) << OFFS) - AW_W'(1);
        if (burst == BURST_FIXED) begin
            res = addr;
        end else if (burst == BURST_WRAP) begin
            res = (addr & ~mask) | (incr & mask);
        end else begin
            res = incr;
        end
        return res;
    endfunction

    function automatic logic [WIDX-1:0] word_idx(input logic [AW_W-1:0] addr);
        return addr[MEM_AB-1:OFFS];
    endfunction

    logic [DW-1:0] mem [MEM_WORDS];

    // ---------------- write path ----------------
    w_state_e                 w_state_q, w_state_d;
    logic [AW_W-1:0]          waddr_q;
    logic [3:0]               awlen_q, wcnt_q;
    logic [1:0]               awburst_q, wresp_q;
    logic [NUM_ID_BITS_P-1:0] awid_q;
    logic                     aw_hs, w_hs, mem_we;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    // A beat with a foreign wid is dropped, and it poisons the rest of the burst
    assign mem_we = w_hs && (wresp_q == RESP_OKAY) && (wid == awid_q);

    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = RESP_OKAY;
        bid       = awid_q;
        unique case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_d = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (wlast || wcnt_q == awlen_q)) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = wresp_q;
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            awid_q    <= '0;
            wcnt_q    <= '0;
            wresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                waddr_q   <= awaddr;
                awlen_q   <= awlen;
                awburst_q <= awburst;
                awid_q    <= awid;
                wcnt_q    <= '0;
                wresp_q   <= burst_resp(awaddr, awsize, awburst, awlen);
            end else if (w_hs) begin
                waddr_q <= next_addr(waddr_q, awburst_q, awlen_q);
                wcnt_q  <= wcnt_q + 4'd1;
                if (wid != awid_q && wresp_q == RESP_OKAY) wresp_q <= RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e                 r_state_q, r_state_d;
    logic [AW_W-1:0]          raddr_q, raddr_nxt;
    logic [3:0]               arlen_q, rcnt_q;
    logic [1:0]               arburst_q, rresp_q, ar_resp;
    logic [NUM_ID_BITS_P-1:0] arid_q;
    logic [DW-1:0]            rdata_q;
    logic                     rlast_q, ar_hs, r_hs;

    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign ar_resp   = burst_resp(araddr, arsize, arburst, arlen);
    assign raddr_nxt = next_addr(raddr_q, arburst_q, arlen_q);

    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rresp     = RESP_OKAY;
        rid       = arid_q;
        rlast     = rlast_q;
        rdata     = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rresp  = rresp_q;
                if (rready && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // rdata is a registered array read, so a same-cycle write is not yet visible
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            arid_q    <= '0;
            rcnt_q    <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                raddr_q   <= araddr;
                arlen_q   <= arlen;
                arburst_q <= arburst;
                arid_q    <= arid;
                rcnt_q    <= '0;
                rresp_q   <= ar_resp;
                rlast_q   <= (arlen == 4'd0);
                rdata_q   <= (ar_resp == RESP_OKAY) ? mem[word_idx(araddr)] : '0;
            end else if (r_hs) begin
                if (rlast_q) begin
                    rlast_q <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    raddr_q <= raddr_nxt;
                    rcnt_q  <= rcnt_q + 4'd1;
                    rlast_q <= (rcnt_q + 4'd1 == arlen_q);
                    rdata_q <= (rresp_q == RESP_OKAY) ? mem[word_idx(raddr_nxt)] : '0;
                end
            end
        end
    end

    logic unused_sideband;
    assign unused_sideband = ^{awcache, awprot, awlock, arcache, arprot, arlock};

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Self-checking bench for axi3_slave_mem: vector table plus R/B scoreboards
// and hand-written stall and mid-burst reset sequences.
module tb_axi3_slave_mem;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        awvalid, awready, wvalid, wlast, wready, bready, bvalid;
    logic        arvalid, arready, rready, rvalid, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [3:0]  awcache, awid, awlen, wstrb, wid, bid, arcache, arid, arlen, rid;
    logic [1:0]  awlock, awburst, bresp, arlock, arburst, rresp;

    always #5 aclk = ~aclk;

    axi3_slave_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awcache(awcache),
        .awprot(awprot), .awlock(awlock), .awburst(awburst), .awid(awid), .awlen(awlen),
        .awready(awready),
        .wvalid(wvalid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wid(wid),
        .wready(wready),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .arcache(arcache),
        .arprot(arprot), .arlock(arlock), .arburst(arburst), .arid(arid), .arlen(arlen),
        .arready(arready),
        .rready(rready), .rvalid(rvalid), .rlast(rlast), .rdata(rdata), .rresp(rresp),
        .rid(rid)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } r_exp_t;
    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [1:0]  lock;
        logic [3:0]  id;
        logic        bad_wid;
        logic [3:0]  strb;
        logic [31:0] dbase;
        logic [1:0]  resp;
    } vec_t;

    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] mem_m [256];
    vec_t        vecs [15];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no handshake expected one within the cycle budget", name);
    endtask

    function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [3:0] len);
        logic [31:0] blk, base;
        if (burst == 2'd0) return a;
        if (burst != 2'd2) return a + 32'd4;
        blk  = (32'(len) + 32'd1) * 32'd4;
        base = a - (a % blk);
        return base + ((a - base + 32'd4) % blk);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [3:0] strb,
                               input logic [31:0] dbase);
        logic [31:0] a, d;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            d = dbase + 32'(i);
            for (int b = 0; b < 4; b++) if (strb[b]) mem_m[a[9:2]][8*b +: 8] = d[8*b +: 8];
            a = tb_next(a, burst, len);
        end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                          input logic last);
        r_exp_t e;
        e.data = d; e.resp = resp; e.id = id; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic push_model_read(input logic [31:0] addr, input logic [3:0] len,
                                   input logic [1:0] burst, input logic [3:0] id,
                                   input logic [1:0] resp);
        logic [31:0] a;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            push_r((resp == 2'd0) ? mem_m[a[9:2]] : 32'd0, resp, id, i == int'(len));
            a = tb_next(a, burst, len);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_awready"}, awready, 1); chk({tag, "_arready"}, arready, 1);
        chk({tag, "_wready"}, wready, 0);   chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_rvalid"}, rvalid, 0);   chk({tag, "_rlast"}, rlast, 0);
        chk({tag, "_bresp"}, bresp, 0);     chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_bid"}, bid, 0);         chk({tag, "_rid"}, rid, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // All channel tasks start and end on a falling edge.
    task automatic send_aw(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [1:0] lock, input logic [3:0] id);
        int n = 0;
        awvalid = 1; awaddr = addr; awlen = len; awburst = burst; awsize = size;
        awlock = lock; awid = id;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        if (!awready) timeout("aw_handshake");
        @(posedge aclk); @(negedge aclk);
        awvalid = 0;
        chk("wready_latency", wready, 1);
    endtask

    task automatic send_w_beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] id,
                               input logic last);
        int n = 0;
        wvalid = 1; wdata = d; wstrb = s; wid = id; wlast = last;
        while (!wready && n < 50) begin @(negedge aclk); n++; end
        if (!wready) timeout("w_handshake");
        @(posedge aclk); @(negedge aclk);
        wvalid = 0; wlast = 0;
    endtask

    task automatic finish_b();
        b_exp_t e;
        int n = 0;
        chk("bvalid_latency", bvalid, 1);
        bready = 1;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!bvalid) timeout("b_handshake");
        e = b_q.pop_front();
        chk("bresp", bresp, e.resp);
        chk("bid", bid, e.id);
        @(posedge aclk); @(negedge aclk);
        bready = 0;
        chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input logic [1:0] lock, input logic [3:0] id, input logic bad_wid,
                               input logic [3:0] strb, input logic [31:0] dbase,
                               input logic [1:0] resp);
        b_exp_t e;
        e.resp = resp; e.id = id;
        b_q.push_back(e);
        send_aw(addr, len, burst, size, lock, id);
        for (int i = 0; i <= int'(len); i++)
            send_w_beat(dbase + 32'(i), strb, bad_wid ? (id ^ 4'h1) : id, i == int'(len));
        finish_b();
        if (resp == 2'd0) model_write(addr, len, burst, strb, dbase);
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id);
        int n = 0;
        arvalid = 1; araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        if (!arready) timeout("ar_handshake");
        @(posedge aclk); @(negedge aclk);
        arvalid = 0;
        chk("rvalid_latency", rvalid, 1);
    endtask

    // rready follows pat (MSB first, repeating); stalled outputs must hold.
    task automatic collect_r(input logic [3:0] len, input logic [3:0] pat);
        r_exp_t      e;
        logic [63:0] snap = '0;
        logic        held = 0;
        int          beats = 0, cyc = 0, p = 0;
        while (beats < int'(len) + 1 && cyc < 200) begin
            rready = pat[3 - (p % 4)];
            p++;
            if (held) chk("stall_hold", {25'd0, rdata, rresp, rid, rlast}, snap);
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    timeout("r_unexpected_beat");
                end else begin
                    e = r_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", rresp, e.resp);
                    chk("rid", rid, e.id);
                    chk("rlast", rlast, e.last);
                end
                beats++;
                held = 0;
            end else if (rvalid) begin
                held = 1;
                snap = {25'd0, rdata, rresp, rid, rlast};
            end else begin
                held = 0;
            end
            @(posedge aclk); @(negedge aclk);
            cyc++;
        end
        rready = 0;
        chk("r_beat_count", beats, int'(len) + 1);
        chk("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected one before the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        awvalid = 0; awaddr = 0; awsize = 0; awcache = 0; awprot = 0; awlock = 0; awburst = 0;
        awid = 0; awlen = 0; wvalid = 0; wlast = 0; wdata = 0; wstrb = 0; wid = 0; bready = 0;
        arvalid = 0; araddr = 0; arsize = 0; arcache = 0; arprot = 0; arlock = 0; arburst = 0;
        arid = 0; arlen = 0; rready = 0;

        repeat (3) @(negedge aclk);
        check_reset("reset");
        aresetn = 1;
        @(negedge aclk);

        //          wr    addr            len   burst size  lock  id    bad   strb   dbase           resp
        vecs[0]  = '{1'b1, 32'h10,        4'd3, 2'd1, 3'd2, 2'd0, 4'd5, 1'b0, 4'hF, 32'hA0,        2'd0};
        vecs[1]  = '{1'b0, 32'h10,        4'd3, 2'd1, 3'd2, 2'd0, 4'd5, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[2]  = '{1'b1, 32'h00,        4'd3, 2'd1, 3'd2, 2'd0, 4'd2, 1'b0, 4'hF, 32'hB0,        2'd0};
        vecs[3]  = '{1'b0, 32'h08,        4'd3, 2'd2, 3'd2, 2'd0, 4'd3, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[4]  = '{1'b1, 32'h0001_0000, 4'd0, 2'd1, 3'd2, 2'd0, 4'd1, 1'b0, 4'hF, 32'hDEAD_0000, 2'd3};
        vecs[5]  = '{1'b0, 32'h00,        4'd0, 2'd1, 3'd2, 2'd0, 4'd1, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[6]  = '{1'b0, 32'h10,        4'd3, 2'd1, 3'd1, 2'd0, 4'd7, 1'b0, 4'hF, 32'h0,         2'd2};
        vecs[7]  = '{1'b1, 32'h20,        4'd2, 2'd0, 3'd2, 2'd1, 4'd4, 1'b0, 4'hF, 32'hC0,        2'd0};
        vecs[8]  = '{1'b0, 32'h20,        4'd1, 2'd0, 3'd2, 2'd0, 4'd4, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[9]  = '{1'b1, 32'h10,        4'd2, 2'd2, 3'd2, 2'd0, 4'd9, 1'b0, 4'hF, 32'h55,        2'd2};
        vecs[10] = '{1'b0, 32'h10,        4'd0, 2'd1, 3'd2, 2'd0, 4'd9, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[11] = '{1'b0, 32'h00,        4'd0, 2'd3, 3'd2, 2'd0, 4'd8, 1'b0, 4'hF, 32'h0,         2'd2};
        vecs[12] = '{1'b1, 32'h20,        4'd1, 2'd1, 3'd2, 2'd0, 4'd4, 1'b1, 4'hF, 32'hE0,        2'd2};
        vecs[13] = '{1'b0, 32'h20,        4'd0, 2'd1, 3'd2, 2'd0, 4'd4, 1'b0, 4'hF, 32'h0,         2'd0};
        vecs[14] = '{1'b0, 32'h0001_0004, 4'd0, 2'd1, 3'd2, 2'd0, 4'd6, 1'b0, 4'hF, 32'h0,         2'd3};

        for (int k = 0; k < 15; k++) begin
            if (vecs[k].wr) begin
                write_burst(vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].size, vecs[k].lock,
                            vecs[k].id, vecs[k].bad_wid, vecs[k].strb, vecs[k].dbase,
                            vecs[k].resp);
            end else begin
                push_model_read(vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].id,
                                vecs[k].resp);
                send_ar(vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].size, vecs[k].id);
                collect_r(vecs[k].len, 4'b1111);
            end
        end

        // Partial strobe merges into the existing word
        write_burst(32'h40, 4'd0, 2'd1, 3'd2, 2'd0, 4'd1, 1'b0, 4'hF, 32'h1234_5678, 2'd0);
        write_burst(32'h40, 4'd0, 2'd1, 3'd2, 2'd0, 4'd1, 1'b0, 4'h3, 32'hFFFF_FFFF, 2'd0);
        push_r(32'h1234_FFFF, 2'd0, 4'd1, 1'b1);
        send_ar(32'h40, 4'd0, 2'd1, 3'd2, 4'd1);
        collect_r(4'd0, 4'b1111);

        // 8-beat read with rready stalls
        write_burst(32'h80, 4'd7, 2'd1, 3'd2, 2'd0, 4'd2, 1'b0, 4'hF, 32'hD0, 2'd0);
        for (int i = 0; i < 8; i++) push_r(32'hD0 + 32'(i), 2'd0, 4'd2, i == 7);
        send_ar(32'h80, 4'd7, 2'd1, 3'd2, 4'd2);
        collect_r(4'd7, 4'b1001);

        // Reset asserted while beat 2 of 4 is offered
        write_burst(32'h60, 4'd3, 2'd1, 3'd2, 2'd0, 4'd6, 1'b0, 4'hF, 32'h11, 2'd0);
        begin
            b_exp_t e;
            e.resp = 2'd0; e.id = 4'd6;
            b_q.push_back(e);
        end
        send_aw(32'h60, 4'd3, 2'd1, 3'd2, 2'd0, 4'd6);
        send_w_beat(32'hF0, 4'hF, 4'd6, 1'b0);
        send_w_beat(32'hF1, 4'hF, 4'd6, 1'b0);
        wvalid = 1; wdata = 32'hF2; wstrb = 4'hF; wid = 4'd6;
        aresetn = 0;
        #1;
        check_reset("midburst_reset");
        @(posedge aclk); @(negedge aclk);
        wvalid = 0;
        aresetn = 1;
        void'(b_q.pop_front());
        mem_m[8'h18] = 32'hF0;
        mem_m[8'h19] = 32'hF1;
        @(negedge aclk);
        push_r(32'hF0, 2'd0, 4'd6, 1'b0);
        push_r(32'hF1, 2'd0, 4'd6, 1'b0);
        push_r(32'h13, 2'd0, 4'd6, 1'b0);
        push_r(32'h14, 2'd0, 4'd6, 1'b1);
        send_ar(32'h60, 4'd3, 2'd1, 3'd2, 4'd6);
        collect_r(4'd3, 4'b1111);
        write_burst(32'h60, 4'd0, 2'd1, 3'd2, 2'd0, 4'd6, 1'b0, 4'hF, 32'h77, 2'd0);

        chk("r_queue_drained", r_q.size(), 0);
        chk("b_queue_drained", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
